// File: rtl/spm_pkg.sv
// Shared definitions for the round-robin multiplier-sharing arbiter:
// state encoding, operand/product widths and the default watchdog limit.
package spm_pkg;

  localparam int OPW         = 8;
  localparam int PRODW       = 16;
  localparam int TIMEOUT_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/spm_rr_pick.sv
// Combinational round-robin picker: starting just after the last-served
// pointer, finds the first active request searching upward with wrap.
module spm_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/spm_share_arb.sv
// Shares one serial-parallel multiplier between NREQ requesters: arbitrates,
// issues the job, waits for a qualified done (with watchdog) and returns it.
module spm_share_arb
  import spm_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*OPW-1:0] req_mc,
  input  logic [NREQ*OPW-1:0] req_mp,
  output logic [NREQ-1:0]     gnt,
  output logic                mul_start,
  output logic [OPW-1:0]      mul_mc,
  output logic [OPW-1:0]      mul_mp,
  input  logic                mul_done,
  input  logic [PRODW-1:0]    mul_pro,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [PRODW-1:0]    rsp_prod,
  output logic                rsp_err,
  output logic                busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t          state, state_nx;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  pick_idx;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_any;
  logic [OPW-1:0]  mc_sel, mp_sel;
  logic [CW-1:0]   wdog;
  logic            seen_busy;
  logic            done_q;
  logic            timeout_hit;

  spm_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    mc_sel = '0;
    mp_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDW'(i)) begin
        mc_sel = req_mc[i*OPW +: OPW];
        mp_sel = req_mp[i*OPW +: OPW];
      end
    end
  end

  // A done that was already high when the job started belongs to the previous
  // job; only trust it once the multiplier has been seen busy.
  assign done_q      = mul_done && seen_busy;
  assign timeout_hit = (wdog == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mul_start = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (pick_any) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        mul_start = 1'b1;
        state_nx  = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_q || timeout_hit) state_nx = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_nx = ST_IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      mul_mc    <= '0;
      mul_mp    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_prod  <= '0;
      rsp_err   <= 1'b0;
      ptr       <= IDW'(NREQ - 1);
      wdog      <= '0;
      seen_busy <= 1'b0;
    end else begin
      gnt <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt    <= pick_gnt;
            ptr    <= pick_idx;
            rsp_id <= pick_idx;
            mul_mc <= mc_sel;
            mul_mp <= mp_sel;
          end
        end
        ST_ISSUE: begin
          wdog      <= '0;
          seen_busy <= 1'b0;
        end
        ST_WAIT: begin
          wdog <= wdog + CW'(1);
          if (!mul_done) seen_busy <= 1'b1;
          // A qualified done in the timeout cycle still wins over the error.
          if (done_q) begin
            rsp_prod  <= mul_pro;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
          end else if (timeout_hit) begin
            rsp_prod  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spm_share_arb.sv
// Scoreboard bench for spm_share_arb: behavioural multiplier, round-robin
// reference model, randomized requests and backpressure.
module tb_spm_share_arb;
  import spm_pkg::*;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 32;

  typedef struct {
    int          id;
    logic [15:0] prod;
    bit          err;
    int          cyc;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req, gnt, req_at_edge;
  logic [NREQ*8-1:0]   req_mc, req_mp;
  logic                mul_start;
  logic [7:0]          mul_mc, mul_mp;
  logic                mul_done;
  logic [15:0]         mul_pro;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [15:0]         rsp_prod;
  logic                rsp_err, busy;

  int   tests = 0, fails = 0, cyc = 0;
  int   mode = 0, ready_mode = 0, mptr = NREQ - 1, stall = 0;
  logic [7:0] op_mc [NREQ];
  logic [7:0] op_mp [NREQ];
  int   grant_log[$];
  exp_t sb[$];
  exp_t mon_e;
  bit   in_rsp = 0;
  int   hs_cyc = -1, exp_gnt_cyc = -1, vlen = 0;
  logic [18:0] held;
  int   exp_order [5] = '{0, 1, 2, 3, 0};

  logic        done_r;
  logic [15:0] pro_r, pro_hold;
  int          stale_c, cnt;
  bit          run;

  spm_share_arb #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_mc(req_mc), .req_mp(req_mp),
    .gnt(gnt), .mul_start(mul_start), .mul_mc(mul_mc), .mul_mp(mul_mp),
    .mul_done(mul_done), .mul_pro(mul_pro), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_prod(rsp_prod),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) req_at_edge <= req;

  function automatic logic [15:0] refProd(input logic [7:0] a, input logic [7:0] b);
    int x, y;
    x = int'(a);
    y = int'(b);
    if (x > 127) x -= 256;
    if (y > 127) y -= 256;
    return 16'(x * y);
  endfunction

  function automatic int rrWinner(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (((r >> j) & NREQ'(1)) != 0) return j;
    end
    return -1;
  endfunction

  // Multiplier stand-in: done stays high until the next start, may linger a
  // few stale cycles, then drops for a random latency before the product.
  always @(posedge clk) begin
    if (rst) begin
      done_r  <= 1'b0;
      pro_r   <= '0;
      run     <= 1'b0;
      stale_c <= 0;
      cnt     <= 0;
    end else if (mul_start) begin
      run      <= 1'b1;
      stale_c  <= int'($urandom_range(0, 2));
      cnt      <= int'($urandom_range(14, 20));
      pro_hold <= refProd(mul_mc, mul_mp);
    end else if (run) begin
      if (stale_c > 0) stale_c <= stale_c - 1;
      else begin
        done_r <= 1'b0;
        if (cnt == 0) begin
          done_r <= 1'b1;
          pro_r  <= pro_hold;
          run    <= 1'b0;
        end else cnt <= cnt - 1;
      end
    end
  end

  assign mul_done = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : done_r;
  assign mul_pro  = pro_r;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [7:0] mc, input logic [7:0] mp);
    req_mc[i*8 +: 8] = mc;
    req_mp[i*8 +: 8] = mp;
    op_mc[i] = mc;
    op_mp[i] = mp;
    req[i]   = 1'b1;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_gnt",       32'(gnt), 0);
    checkOutput("rst_mul_start", 32'(mul_start), 0);
    checkOutput("rst_mul_ops",   32'({mul_mc, mul_mp}), 0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("rst_rsp_id",    32'(rsp_id), 0);
    checkOutput("rst_rsp_prod",  32'(rsp_prod), 0);
    checkOutput("rst_rsp_err",   32'(rsp_err), 0);
    checkOutput("rst_busy",      32'(busy), 0);
  endtask

  task automatic serviceGrants(input int n, input bit reassert);
    int   got, budget, w;
    exp_t e;
    got = 0;
    while (got < n) begin
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (gnt == '0 && budget < 300);
      if (gnt == '0) begin
        checkOutput("gnt_wait_expired", 32'(|gnt), 1);
        return;
      end
      w = rrWinner(req_at_edge, mptr);
      checkOutput("gnt_onehot", 32'($onehot(gnt)), 1);
      if (w < 0) begin
        checkOutput("gnt_without_request", 32'(gnt), 0);
        return;
      end
      checkOutput("gnt_winner", 32'(gnt), 32'(32'd1 << w));
      checkOutput("issue_start", 32'(mul_start), 1);
      checkOutput("issue_operands", 32'({mul_mc, mul_mp}), 32'({op_mc[w], op_mp[w]}));
      checkOutput("issue_busy", 32'(busy), 1);
      e.id   = w;
      e.err  = (mode != 0);
      e.prod = e.err ? 16'h0000 : refProd(op_mc[w], op_mp[w]);
      e.cyc  = e.err ? cyc + 1 + TIMEOUT : -1;
      sb.push_back(e);
      grant_log.push_back(w);
      mptr = w;
      got++;
      @(posedge clk); #1;
      req[w] = 1'b0;
      @(negedge clk);
      checkOutput("gnt_pulse_width", 32'({gnt, mul_start}), 0);
      if (reassert) begin
        @(posedge clk); #1;
        applyStimulus(w, 8'($urandom), 8'($urandom));
      end
    end
  endtask

  task automatic waitDrain();
    int budget;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while ((sb.size() != 0 || busy || rsp_valid) && budget < 400);
    checkOutput("drain_queue", 32'(sb.size()), 0);
    checkOutput("drain_busy", 32'(busy), 0);
  endtask

  // Response-side ready generator: always ready, random, or a 10-cycle stall.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (rsp_valid) begin
            if (stall < 10) begin
              rsp_ready = 1'b0;
              stall++;
            end else rsp_ready = 1'b1;
          end else begin
            stall     = 0;
            rsp_ready = 1'b0;
          end
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on each new response and polices the
  // response channel and post-handshake arbitration timing.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        in_rsp      = 0;
        hs_cyc      = -1;
        exp_gnt_cyc = -1;
      end else begin
        if (exp_gnt_cyc == cyc) begin
          checkOutput("gnt_after_handshake", 32'(gnt != '0), 1);
          exp_gnt_cyc = -1;
        end
        if (hs_cyc >= 0 && cyc == hs_cyc + 1) begin
          if (req != '0) exp_gnt_cyc = cyc + 1;
          hs_cyc = -1;
        end
        if (rsp_valid) begin
          checkOutput("resp_quiet", 32'({mul_start, gnt, !busy}), 0);
          if (!in_rsp) begin
            if (sb.size() == 0) checkOutput("rsp_unexpected", 32'(sb.size()), 1);
            else begin
              mon_e = sb.pop_front();
              checkOutput("rsp_id",   32'(rsp_id), 32'(mon_e.id));
              checkOutput("rsp_prod", 32'(rsp_prod), 32'(mon_e.prod));
              checkOutput("rsp_err",  32'(rsp_err), 32'(mon_e.err));
              if (mon_e.cyc >= 0) checkOutput("rsp_timeout_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
            held   = {rsp_id, rsp_prod, rsp_err};
            in_rsp = 1;
            vlen   = 0;
          end else begin
            checkOutput("rsp_stable", 32'({rsp_id, rsp_prod, rsp_err}), 32'(held));
          end
          vlen++;
          if (rsp_ready) begin
            in_rsp = 0;
            hs_cyc = cyc;
            if (ready_mode == 0)      checkOutput("valid_len", 32'(vlen), 1);
            else if (ready_mode == 2) checkOutput("stall_len", 32'(vlen), 11);
          end
        end else if (in_rsp) begin
          checkOutput("rsp_dropped", 32'(rsp_valid), 1);
          in_rsp = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    rst    = 1'b1;
    req    = '0;
    req_mc = '0;
    req_mp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetValues();
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request and a signed-operand product.
    applyStimulus(2, 8'h03, 8'h05);
    serviceGrants(1, 1'b0);
    waitDrain();
    @(posedge clk); #1;
    applyStimulus(0, 8'hFE, 8'h07);
    serviceGrants(1, 1'b0);
    waitDrain();

    // Backpressure with a second requester waiting behind the stall.
    ready_mode = 2;
    @(posedge clk); #1;
    applyStimulus(1, 8'h11, 8'h22);
    applyStimulus(3, 8'h80, 8'h80);
    serviceGrants(2, 1'b0);
    waitDrain();
    ready_mode = 0;

    // Done stuck high (never qualified) and stuck low: both must time out.
    mode = 1;
    @(posedge clk); #1;
    applyStimulus(2, 8'h09, 8'h09);
    serviceGrants(1, 1'b0);
    waitDrain();
    mode = 2;
    @(posedge clk); #1;
    applyStimulus(0, 8'h7F, 8'h81);
    serviceGrants(1, 1'b0);
    waitDrain();
    mode = 0;

    // Randomized traffic with random backpressure.
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 1) == 1) applyStimulus(i, 8'($urandom), 8'($urandom));
      if (req == '0) applyStimulus(int'($urandom_range(0, NREQ - 1)), 8'($urandom), 8'($urandom));
      serviceGrants(1, 1'b0);
    end
    serviceGrants($countones(req), 1'b0);
    waitDrain();
    ready_mode = 0;

    // Reset in the middle of WAIT, then full round-robin from requester 0.
    @(posedge clk); #1;
    applyStimulus(3, 8'h05, 8'h06);
    serviceGrants(1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 8'($urandom), 8'($urandom));
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    grant_log.delete();
    mptr = NREQ - 1;
    @(negedge clk);
    checkResetValues();
    serviceGrants(5, 1'b1);
    checkOutput("rr_count", 32'(grant_log.size()), 5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      checkOutput("rr_order", 32'(grant_log[k]), 32'(exp_order[k]));
    serviceGrants($countones(req), 1'b0);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spm_share_arb.md
Name: spm_share_arb

Overview:
Round-robin scheduler that shares one serial-parallel multiplier controller (fsm: start/mc/mp in, pro/done out) between NREQ requesters. Captures the winner's operands and pulses the multiplier start. Waits for done, then returns the 16-bit product with the requester id on a valid/ready response port. Includes a watchdog that flags a multiplier that never completes.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester id width, equal to clog2(NREQ)
TIMEOUT, 32, maximum cycles in WAIT before aborting (the multiplier needs about 18)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset; the same net also resets the shared multiplier
req  in  NREQ  per-requester request level; held until granted
req_mc  in  NREQ*8  multiplicand; slice i belongs to requester i
req_mp  in  NREQ*8  multiplier; slice i belongs to requester i
gnt  out  NREQ  one-hot, one-cycle pulse; operands of that requester are captured this cycle
mul_start  out  1  to multiplier start; one-cycle pulse
mul_mc  out  8  to multiplier mc; registered copy of captured operand
mul_mp  out  8  to multiplier mp; registered copy of captured operand
mul_done  in  1  from multiplier done (level; stays high until the next start)
mul_pro  in  16  from multiplier pro
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_id  out  IDW  id of the served requester
rsp_prod  out  16  product (0 when rsp_err=1)
rsp_err  out  1  the watchdog expired for this job
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous): state=IDLE; gnt=0; mul_start=0; mul_mc=mul_mp=0; rsp_valid=0; rsp_id=0; rsp_prod=0; rsp_err=0; busy=0; last-served pointer=NREQ-1, so requester 0 has first priority.
- Arbitration (in IDLE only):
  - Scan start = pointer+1 mod NREQ; search upward with wrap.
  - The first i with req[i]=1 wins.
  - gnt[i]=1 for exactly that cycle.
  - Operands and id are latched; pointer<=i.
  - Go to ISSUE.
- Requests not granted stay pending; there is no queueing beyond the req level. A requester must drop req the cycle after its gnt, or it is treated as a new request.
- ISSUE (1 cycle): mul_start=1 with mul_mc/mul_mp stable; go to WAIT; watchdog counter <= 0.
- WAIT:
  - mul_done is qualified by a seen_busy flag. seen_busy is set on the first WAIT cycle with mul_done=0. mul_done=1 before seen_busy is stale and is ignored.
  - On mul_done=1 with seen_busy=1: rsp_prod<=mul_pro, rsp_err<=0, rsp_valid<=1; go to RESP.
  - Counter increments each WAIT cycle. When counter==TIMEOUT-1 without a qualified done: rsp_prod<=0, rsp_err<=1, rsp_valid<=1; go to RESP.
  - A qualified done in the same cycle as the timeout wins, so no error is reported.
- RESP:
  - rsp_valid, rsp_id, rsp_prod and rsp_err hold stable until rsp_ready=1.
  - On the handshake, rsp_valid<=0 and state goes to IDLE.
  - rsp_ready is ignored whenever rsp_valid=0.
- Throughput: at most one job in flight.
  - Arbitration happens in the first IDLE cycle after a handshake, so there is one dead cycle between jobs.
  - Latency from gnt to rsp_valid is the multiplier latency + 2 cycles.
- Arithmetic: the product is passed through unchanged; the block does no sign handling.
- Reset during any state: abort immediately and discard the job; the multiplier is reset by the same rst.
- States live in a 2-bit encoding: IDLE=0, ISSUE=1, WAIT=2, RESP=3. An illegal state returns to IDLE.

Decomposition:
- Shared package spm_pkg:
  - state encoding constants;
  - operand width 8 and product width 16;
  - default TIMEOUT.
- One sub-module, spm_rr_pick:
  - inputs: req vector and pointer;
  - outputs: one-hot grant and encoded index, combinational;
  - the pointer register stays in spm_share_arb.
- The multiplier fsm is instantiated at the level above, not inside this block.

Test Plan:
- Single request: req[2]=1, mc=3, mp=5 -> gnt=0100 for 1 cycle, one mul_start pulse, then rsp_valid with id=2, prod=0x000F, err=0; with rsp_ready held high, rsp_valid lasts 1 cycle.
- Signed operands: req[0], mc=0xFE (-2), mp=0x07 -> rsp_prod=0xFFF2, id=0.
- Round-robin: req=1111 held (each requester re-asserts after service) -> grant order 0,1,2,3,0; no requester is granted twice while another is pending.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> outputs stable, no new gnt or mul_start; ready=1 -> handshake, and next gnt 2 cycles later.
- Stale done and timeout:
  - mul_done tied high -> ignored (no seen_busy);
  - mul_done tied low -> rsp_err=1 and prod=0 exactly TIMEOUT cycles after entering WAIT.
- Reset mid-WAIT: assert rst for 1 cycle -> next cycle all outputs are at reset values, and the next grant goes to requester 0 if it is requesting.
